decode_stage_p: RTL and testbench

//  Parametrised successor of the single-issue ID stage. It merges register file,

---
 rtl/decode_stage_p_if.sv | 40 ++++
 rtl/decode_stage_p.sv | 213 +++++++++++++++++++++
 tb/tb_decode_stage_p.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_p_if.sv
// ID-side and EX-side valid/ready bundle for decode_stage_p.
// master is the decode stage; slave is the upstream/execute environment.
interface decode_stage_p_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pc;
  logic [RAW-1:0]  ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_reg_we;
  logic            ex_is_load;
  logic            ex_illegal;

  modport master (
    input  id_valid, id_instr, id_pc, ex_ready,
    output id_ready, ex_valid, ex_rs1_data,
    output ex_rs2_data, ex_imm, ex_pc, ex_rd,
    output ex_opcode, ex_funct3, ex_funct7b5,
    output ex_reg_we, ex_is_load, ex_illegal
  );

  modport slave (
    output id_valid, id_instr, id_pc, ex_ready,
    input  id_ready, ex_valid, ex_rs1_data,
    input  ex_rs2_data, ex_imm, ex_pc, ex_rd,
    input  ex_opcode, ex_funct3, ex_funct7b5,
    input  ex_reg_we, ex_is_load, ex_illegal
  );
endinterface

// File: rtl/decode_stage_p.sv
// ID stage: RF, immediates, branch resolve, hazard stall, ID/EX register.
// Define RF_BYPASS_EN to forward same-cycle writeback into the read ports.
module decode_stage_p #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int RAW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_stage_p_if.master  bus,
  input  logic              wb_we,
  input  logic [RAW-1:0]    wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [RAW-1:0]  rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_we;
    logic            is_load;
    logic            illegal;
  } id_ex_t;

  logic [XLEN-1:0] rf [NUM_REGS];
  logic [31:0]     ins;
  logic [6:0]      opc;
  logic [RAW-1:0]  rs1_idx;
  logic [RAW-1:0]  rs2_idx;
  logic [RAW-1:0]  rd_idx;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic            is_lui, is_auipc, is_jal, is_jalr;
  logic            is_br, is_load, is_store, is_imm;
  logic            is_op, is_fence, is_sys;
  logic            legal, writes, use_rs1, use_rs2;
  logic            src_match, hazard, load_en;
  logic            transfer, taken;
  logic            ex_valid_q;
  id_ex_t          ex_q;
  id_ex_t          ex_d;

  assign ins     = bus.id_instr;
  assign opc     = ins[6:0];
  assign rs1_idx = ins[15 +: RAW];
  assign rs2_idx = ins[20 +: RAW];
  assign rd_idx  = ins[7 +: RAW];

  assign is_lui   = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_jal   = opc == OP_JAL;
  assign is_jalr  = opc == OP_JALR;
  assign is_br    = opc == OP_BR;
  assign is_load  = opc == OP_LOAD;
  assign is_store = opc == OP_STORE;
  assign is_imm   = opc == OP_IMM;
  assign is_op    = opc == OP_OP;
  assign is_fence = opc == OP_FENCE;
  assign is_sys   = opc == OP_SYS;

  assign legal = is_lui | is_auipc | is_jal
               | is_jalr | is_br | is_load
               | is_store | is_imm | is_op
               | is_fence | is_sys;
  assign writes = is_lui | is_auipc | is_jal
                | is_jalr | is_load | is_imm
                | is_op;
  assign use_rs1 = is_jalr | is_br | is_load
                 | is_store | is_imm | is_op;
  assign use_rs2 = is_op | is_store | is_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (rs1_idx == '0) ? '0 : rf[rs1_idx];
`ifdef RF_BYPASS_EN
    if (wb_we && wb_rd == rs1_idx && rs1_idx != '0)
      rs1_data = wb_data;
`endif
  end

  always_comb begin
    rs2_data = (rs2_idx == '0) ? '0 : rf[rs2_idx];
`ifdef RF_BYPASS_EN
    if (wb_we && wb_rd == rs2_idx && rs2_idx != '0)
      rs2_data = wb_data;
`endif
  end

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_jalr, is_load, is_imm,
      is_fence, is_sys:
        imm = XLEN'($signed(ins[31:20]));
      is_store:
        imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      is_br:
        imm = XLEN'($signed({ins[31], ins[7],
              ins[30:25], ins[11:8], 1'b0}));
      is_lui, is_auipc:
        imm = XLEN'($signed({ins[31:12], 12'h000}));
      is_jal:
        imm = XLEN'($signed({ins[31], ins[19:12],
              ins[20], ins[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  always_comb begin
    case (ins[14:12])
      3'b000:  taken = rs1_data == rs2_data;
      3'b001:  taken = rs1_data != rs2_data;
      3'b100:  taken = $signed(rs1_data) < $signed(rs2_data);
      3'b101:  taken = $signed(rs1_data) >= $signed(rs2_data);
      3'b110:  taken = rs1_data < rs2_data;
      3'b111:  taken = rs1_data >= rs2_data;
      default: taken = 1'b0;
    endcase
  end

  assign br_target = bus.id_pc + imm;
  assign jalr_sum  = rs1_data + imm;

  // A producer in ID/EX blocks loads' consumers and in-decode branch compares
  assign src_match = (use_rs1 && rs1_idx == ex_q.rd)
                   || (use_rs2 && rs2_idx == ex_q.rd);
  assign hazard = ex_valid_q && src_match
                && ((ex_q.is_load && ex_q.rd != '0)
                 || ((is_br || is_jalr) && ex_q.reg_we));

  assign load_en      = !ex_valid_q || bus.ex_ready;
  assign bus.id_ready = rst_n && load_en && !hazard && !flush;
  assign transfer     = bus.id_valid && bus.id_ready;

  assign redirect_valid = transfer
                        && (is_jal || is_jalr || (is_br && taken));
  assign redirect_pc = !redirect_valid ? '0
                     : is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                     : br_target;

  always_comb begin
    ex_d          = '0;
    ex_d.rs1      = rs1_data;
    ex_d.rs2      = rs2_data;
    ex_d.imm      = imm;
    ex_d.pc       = bus.id_pc;
    ex_d.rd       = rd_idx;
    ex_d.opcode   = opc;
    ex_d.funct3   = ins[14:12];
    ex_d.funct7b5 = ins[30];
    ex_d.reg_we   = writes && rd_idx != '0;
    ex_d.is_load  = is_load;
    ex_d.illegal  = !legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (load_en) begin
      ex_valid_q <= transfer;
      if (transfer)
        ex_q <= ex_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_rs1_data = ex_q.rs1;
  assign bus.ex_rs2_data = ex_q.rs2;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_opcode   = ex_q.opcode;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_funct7b5 = ex_q.funct7b5;
  assign bus.ex_reg_we   = ex_q.reg_we;
  assign bus.ex_is_load  = ex_q.is_load;
  assign bus.ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: directed scenarios plus random traffic.
// Expected ops come from an instruction-level model of the decode rules.
module tb_decode_stage_p;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OP    = 7'b0110011;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        we;
    logic        ld;
    logic        ill;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  decode_stage_p_if #(.XLEN(32), .RAW(5)) bus ();

  decode_stage_p #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  logic [31:0] mrf [32];
  bit          occ;
  op_t         cur;
  op_t         q [$];
  bit          e_ready, e_rv, e_occ, m_xfer;
  logic [31:0] e_rpc;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(int v, int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 32'(r);
  endfunction

  function automatic logic [31:0] rd_m(logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wb_we && wb_rd == idx) return wb_data;
`endif
    return mrf[idx];
  endfunction

  function automatic op_t decode_m(logic [31:0] ins, logic [31:0] pc,
                                   logic [31:0] a, logic [31:0] b);
    op_t o;
    int  v;
    o.rs1 = a;
    o.rs2 = b;
    o.pc  = pc;
    o.rd  = ins[11:7];
    o.opc = ins[6:0];
    o.f3  = ins[14:12];
    o.f7  = ins[30];
    o.ld  = o.opc == LOAD;
    o.we  = (o.rd != 5'd0)
          && (o.opc inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP});
    o.ill = !(o.opc inside {LUI, AUIPC, JAL, JALR, BR, LOAD,
                            STORE, OPIMM, OP, 7'b0001111, 7'b1110011});
    case (o.opc)
      JALR, LOAD, OPIMM: o.imm = sx(int'(ins[31:20]), 12);
      STORE: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        o.imm = sx(v, 12);
      end
      BR: begin
        v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
          + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        o.imm = sx(v, 13);
      end
      LUI, AUIPC: o.imm = {ins[31:12], 12'h000};
      JAL: begin
        v = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096
          + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        o.imm = sx(v, 21);
      end
      default: o.imm = 32'd0;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model
  task automatic step(input bit v, input logic [31:0] ins,
                      input logic [31:0] pc, input bit rdy,
                      input bit we, input logic [4:0] wr,
                      input logic [31:0] wd, input bit fl);
    logic [6:0]  opc;
    logic [4:0]  r1, r2;
    logic [31:0] a, b;
    bit          u1, u2, mt, hz, le, tk;
    op_t         o;
    bus.id_valid = v;
    bus.id_instr = ins;
    bus.id_pc    = pc;
    bus.ex_ready = rdy;
    wb_we        = we;
    wb_rd        = wr;
    wb_data      = wd;
    flush        = fl;
    opc = ins[6:0];
    r1  = ins[19:15];
    r2  = ins[24:20];
    a   = rd_m(r1);
    b   = rd_m(r2);
    u1  = opc inside {JALR, BR, LOAD, STORE, OPIMM, OP};
    u2  = opc inside {OP, STORE, BR};
    mt  = occ && cur.rd != 5'd0
        && ((u1 && r1 == cur.rd) || (u2 && r2 == cur.rd));
    hz  = (mt && cur.ld) || (mt && cur.we && opc inside {BR, JALR});
    le  = !occ || rdy;
    e_ready = le && !hz && !fl;
    m_xfer  = v && e_ready;
    e_occ   = occ;
    e_rv    = 1'b0;
    e_rpc   = 32'd0;
    o = decode_m(ins, pc, a, b);
    if (m_xfer) begin
      case (ins[14:12])
        3'd0: tk = a == b;
        3'd1: tk = a != b;
        3'd4: tk = $signed(a) < $signed(b);
        3'd5: tk = $signed(a) >= $signed(b);
        3'd6: tk = a < b;
        3'd7: tk = a >= b;
        default: tk = 1'b0;
      endcase
      if (opc == JAL) begin
        e_rv = 1'b1; e_rpc = pc + o.imm;
      end else if (opc == JALR) begin
        e_rv = 1'b1; e_rpc = (a + o.imm) & ~32'd1;
      end else if (opc == BR && tk) begin
        e_rv = 1'b1; e_rpc = pc + o.imm;
      end
    end
    if (fl) begin
      if (occ) void'(q.pop_front());
      occ = 1'b0;
    end else if (le) begin
      occ = m_xfer;
      if (m_xfer) begin
        cur = o;
        q.push_back(o);
      end
    end
    if (we && wr != 5'd0) mrf[wr] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit we, input logic [4:0] wr,
                      input logic [31:0] wd);
    step(1'b0, 32'h13, 32'd0, 1'b1, we, wr, wd, 1'b0);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b1, ins, pc, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      done = m_xfer;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: instr %h never accepted", ins);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_instr = 32'h13;
    bus.id_pc    = 32'd0;
    bus.ex_ready = 1'b1;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0;
    occ = 1'b0;
    cur = '0;
    q.delete();
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    #2;
    check("rst_rs1", bus.ex_rs1_data, 32'd0);
    check("rst_rs2", bus.ex_rs2_data, 32'd0);
    check("rst_imm", bus.ex_imm, 32'd0);
    check("rst_pc", bus.ex_pc, 32'd0);
    check("rst_ctl", {11'd0, bus.ex_valid, bus.ex_rd, bus.ex_opcode,
          bus.ex_funct3, bus.ex_funct7b5, bus.ex_reg_we,
          bus.ex_is_load, bus.ex_illegal, redirect_valid}, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("id_ready", {31'd0, bus.id_ready}, {31'd0, e_ready});
      check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, e_occ});
      check("redir_v", {31'd0, redirect_valid}, {31'd0, e_rv});
      if (e_rv) check("redir_pc", redirect_pc, e_rpc);
      if (e_occ && !flush) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got valid op expected none queued");
        end else begin
          check("ex_rs1", bus.ex_rs1_data, q[0].rs1);
          check("ex_rs2", bus.ex_rs2_data, q[0].rs2);
          check("ex_imm", bus.ex_imm, q[0].imm);
          check("ex_pc", bus.ex_pc, q[0].pc);
          check("ex_ctl",
            {12'd0, bus.ex_rd, bus.ex_opcode, bus.ex_funct3,
             bus.ex_funct7b5, bus.ex_reg_we, bus.ex_is_load,
             bus.ex_illegal},
            {12'd0, q[0].rd, q[0].opc, q[0].f3, q[0].f7,
             q[0].we, q[0].ld, q[0].ill});
          if (bus.ex_ready) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd,
      logic [2:0] f3, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs1,
      logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, OP};
  endfunction

  function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1,
      logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
  endfunction

  logic [6:0] ops [11] = '{LUI, AUIPC, JAL, JALR, BR, LOAD,
                           STORE, OPIMM, OP, 7'h00, 7'h7F};

  initial begin
    logic [31:0] ins;
    bit          v, rdy, we, fl;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    idle(1'b1, 5'd0, 32'hDEAD);
    for (int i = 0; i < 32; i++) issue(enc_r(5'd0, 5'(i), 5'd0), 32'd0);

    idle(1'b1, 5'd5, 32'h1234);
    issue(enc_i(OPIMM, 5'd6, 3'd0, 5'd5, 12'hFFF), 32'h40);

    issue(enc_i(LOAD, 5'd7, 3'd2, 5'd1, 12'd0), 32'h44);
    issue(enc_r(5'd8, 5'd7, 5'd7), 32'h48);

    idle(1'b1, 5'd1, 32'd5);
    idle(1'b1, 5'd2, 32'd5);
    issue(enc_b(3'd0, 5'd1, 5'd2, 13'd16), 32'h100);
    issue(enc_b(3'd1, 5'd1, 5'd2, 13'd16), 32'h104);

    idle(1'b1, 5'd9, 32'h200);
    step(1'b1, enc_i(OPIMM, 5'd9, 3'd0, 5'd0, 12'h200), 32'h108,
         1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (2)
      step(1'b1, enc_i(JALR, 5'd1, 3'd0, 5'd9, 12'd3), 32'h10C,
           1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    issue(enc_i(JALR, 5'd1, 3'd0, 5'd9, 12'd3), 32'h10C);

    step(1'b1, enc_r(5'd10, 5'd1, 5'd2), 32'h110,
         1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (3)
      step(1'b1, enc_i(OPIMM, 5'd11, 3'd0, 5'd1, 12'd1), 32'h114,
           1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, enc_i(OPIMM, 5'd11, 3'd0, 5'd1, 12'd1), 32'h114,
         1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b0, 5'd0, 32'd0);
    step(1'b1, enc_r(5'd4, 5'd3, 5'd0), 32'h118,
         1'b1, 1'b1, 5'd3, 32'd9, 1'b0);
    idle(1'b0, 5'd0, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 10)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 3) != 0;
      we  = $urandom_range(0, 1) != 0;
      fl  = $urandom_range(0, 19) == 0;
      step(v, ins, $urandom & 32'hFFFF_FFFC, rdy, we,
           5'($urandom_range(0, 7)),
           ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3))
                                       : $urandom,
           fl);
    end
    idle(1'b0, 5'd0, 32'd0);
    idle(1'b0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
